// File: rtl/computer_top.sv
// computer_top: accumulator machine with a 16x8 unified instruction/data memory and a 3-clock instruction cycle.
// Defining COMPUTER_MUL_EN enables opcode 9 (MUL); when it is undefined, opcode 9 is a NOP.
module computer_top (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_en,
   input  logic [3:0] load_addr,
   input  logic [7:0] load_data,
   output logic [3:0] pc,
   output logic [7:0] acc,
   output logic       carry,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       halted
);
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_JMP = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'h8;
   localparam logic [3:0] OP_MUL = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_HALT} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] acc_q, acc_d;
   logic          carry_q, carry_d;
   logic [DW-1:0] ir_q, ir_d;
   logic [DW-1:0] mdr_q, mdr_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          halted_q, halted_d;

   logic [DW-1:0] mem_q [DEPTH];
   logic          sta_we_c;
   logic          mem_we_c;
   logic [AW-1:0] mem_waddr_c;
   logic [DW-1:0] mem_wdata_c;
   logic [DW:0]   sum_c;
   logic [DW:0]   diff_c;
`ifdef COMPUTER_MUL_EN
   logic [2*DW-1:0] prod_c;
`endif

   // Next-state and datapath for the fetch/decode/execute cycle
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      ir_d        = ir_q;
      mdr_d       = mdr_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      halted_d    = halted_q;
      sta_we_c    = 1'b0;
      sum_c       = {1'b0, acc_q} + {1'b0, mdr_q};
      diff_c      = {1'b0, acc_q} - {1'b0, mdr_q};
`ifdef COMPUTER_MUL_EN
      prod_c      = (2*DW)'(acc_q) * (2*DW)'(mdr_q);
`endif
      case (state_q)
         S_FETCH: begin
            ir_d    = mem_q[pc_q];
            pc_d    = pc_q + AW'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            mdr_d   = mem_q[ir_q[AW-1:0]];
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            state_d = S_FETCH;
            case (ir_q[7:4])
               OP_LDA: acc_d = mdr_q;
               OP_STA: sta_we_c = 1'b1;
               OP_ADD: {carry_d, acc_d} = sum_c;
               OP_SUB: {carry_d, acc_d} = diff_c;
               OP_AND: acc_d = acc_q & mdr_q;
               OP_JMP: pc_d = ir_q[AW-1:0];
               OP_JZ: begin
                  if (acc_q == '0) pc_d = ir_q[AW-1:0];
               end
               OP_OUT: begin
                  out_data_d  = acc_q;
                  out_valid_d = 1'b1;
               end
`ifdef COMPUTER_MUL_EN
               OP_MUL: begin
                  acc_d   = prod_c[DW-1:0];
                  carry_d = |prod_c[2*DW-1:DW];
               end
`endif
               OP_HLT: begin
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
               default: ;
            endcase
         end
         S_HALT: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         pc_q        <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         ir_q        <= '0;
         mdr_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         ir_q        <= ir_d;
         mdr_q       <= mdr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         halted_q    <= halted_d;
      end
   end

   // Program loading owns the write port while in reset; STA owns it otherwise
   always_comb begin
      mem_we_c    = sta_we_c;
      mem_waddr_c = ir_q[AW-1:0];
      mem_wdata_c = acc_q;
      if (!reset) begin
         mem_we_c    = load_en;
         mem_waddr_c = load_addr;
         mem_wdata_c = load_data;
      end
   end

   // Memory contents survive reset so a loaded program is kept
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
   end

   assign pc        = pc_q;
   assign acc       = acc_q;
   assign carry     = carry_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign halted    = halted_q;
endmodule

// File: tb/tb_computer_top.sv
// tb_computer_top: runs directed and random programs on computer_top against an instruction-level model.
// Honors COMPUTER_MUL_EN in the same way as the design.
module tb_computer_top;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load_en = 1'b0;
   logic [3:0] load_addr = '0;
   logic [7:0] load_data = '0;
   logic [3:0] pc;
   logic [7:0] acc;
   logic       carry;
   logic [7:0] out_data;
   logic       out_valid;
   logic       halted;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] img [16];
   int m_mem [16];
   int m_pc, m_acc, m_carry, m_od, m_ov, m_halt;
   int ov_cnt;

   computer_top dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .pc(pc), .acc(acc), .carry(carry),
      .out_data(out_data), .out_valid(out_valid), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = 0; m_acc = 0; m_carry = 0; m_od = 0; m_ov = 0; m_halt = 0;
      ov_cnt = 0;
   endtask

   // Executes one whole instruction of the architectural model
   task automatic model_step();
      int ir, a, m, r;
      m_ov = 0;
      if (m_halt != 0) return;
      ir   = m_mem[m_pc];
      m_pc = (m_pc + 1) % 16;
      a    = ir % 16;
      m    = m_mem[a];
      case (ir / 16)
         1: m_acc = m;
         2: m_mem[a] = m_acc;
         3: begin r = m_acc + m; m_carry = (r > 255) ? 1 : 0; m_acc = r % 256; end
         4: begin m_carry = (m_acc < m) ? 1 : 0; m_acc = (m_acc - m + 256) % 256; end
         5: m_acc = m_acc & m;
         6: m_pc = a;
         7: if (m_acc == 0) m_pc = a;
         8: begin m_od = m_acc; m_ov = 1; end
`ifdef COMPUTER_MUL_EN
         9: begin r = m_acc * m; m_carry = (r > 255) ? 1 : 0; m_acc = r % 256; end
`endif
         15: m_halt = 1;
         default: ;
      endcase
   endtask

   task automatic clear_img();
      for (int i = 0; i < 16; i++) img[i] = 8'h00;
   endtask

   // Loads img while in reset, checks the reset state, then releases reset
   task automatic load_prog();
      reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         load_en = 1'b1; load_addr = 4'(i); load_data = img[i];
         @(posedge clk); @(negedge clk);
      end
      load_en = 1'b0;
      for (int i = 0; i < 16; i++) m_mem[i] = int'(img[i]);
      m_reset();
      chk("rst_state", int'({pc, acc, carry, out_data, out_valid, halted}), 0);
      reset = 1'b1;
   endtask

   // Three clocks with write-port noise (must be ignored), then compare with the model
   task automatic run_instr();
      for (int c = 0; c < 3; c++) begin
         load_en = 1'($urandom); load_addr = 4'($urandom); load_data = 8'($urandom);
         @(posedge clk); @(negedge clk);
         if (c < 2) chk("ov_mid", int'(out_valid), 0);
      end
      load_en = 1'b0;
      model_step();
      if (out_valid) ov_cnt++;
      chk("pc", int'(pc), m_pc);
      chk("acc", int'(acc), m_acc);
      chk("carry", int'(carry), m_carry);
      chk("out_valid", int'(out_valid), m_ov);
      chk("out_data", int'(out_data), m_od);
      chk("halted", int'(halted), m_halt);
   endtask

   initial begin
      @(negedge clk);

      // Add two operands and output the sum
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'h80; img[3] = 8'hF0;
      img[14] = 8'h05; img[15] = 8'h07;
      load_prog();
      repeat (5) run_instr();
      chk("add_out", int'(out_data), 8'h0C);
      chk("add_ovcnt", ov_cnt, 1);
      chk("add_halt", int'({halted, pc}), 5'h14);

      // ADD overflow sets carry
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'hF0; img[14] = 8'hFF; img[15] = 8'h02;
      load_prog();
      repeat (4) run_instr();
      chk("add_ovf", int'({carry, acc}), 9'h101);

      // SUB underflow sets borrow
      clear_img();
      img[0] = 8'h1E; img[1] = 8'h4F; img[2] = 8'hF0; img[14] = 8'h01; img[15] = 8'h02;
      load_prog();
      repeat (4) run_instr();
      chk("sub_brw", int'({carry, acc}), 9'h1FF);

      // JZ taken
      clear_img();
      img[0] = 8'h1F; img[1] = 8'h73; img[2] = 8'hF0; img[3] = 8'h80; img[4] = 8'hF0;
      load_prog();
      repeat (5) run_instr();
      chk("jz_taken", int'({halted, pc}), 5'h15);
      chk("jz_taken_ov", ov_cnt, 1);

      // JZ not taken
      img[15] = 8'h01;
      load_prog();
      repeat (5) run_instr();
      chk("jz_not", int'({halted, pc}), 5'h13);
      chk("jz_not_ov", ov_cnt, 0);

      // Opcode 9: MUL when enabled, NOP otherwise
      clear_img();
      img[0] = 8'h1F; img[1] = 8'h9E; img[2] = 8'h80; img[3] = 8'hF0;
      img[14] = 8'h10; img[15] = 8'h20;
      load_prog();
      repeat (4) run_instr();
`ifdef COMPUTER_MUL_EN
      chk("mul", int'({carry, out_data}), 9'h100);
`else
      chk("mul_nop", int'({carry, out_data}), 9'h020);
`endif

      // Reset mid-EXECUTE of a JMP 0 loop
      clear_img();
      img[0] = 8'h60;
      load_prog();
      repeat (2) run_instr();
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("jmp_exec_pc", int'(pc), 1);
      reset = 1'b0;
      #1;
      chk("async_rst", int'({pc, acc, carry, out_data, out_valid, halted}), 0);
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      m_reset();
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); @(negedge clk);
         chk("jmp_pc_seq", int'(pc), (c % 3 == 2) ? 0 : 1);
      end
      chk("jmp_halt", int'(halted), 0);

      // Reset during STA EXECUTE must not write memory
      clear_img();
      img[0] = 8'h1F; img[1] = 8'h2E; img[14] = 8'h55; img[15] = 8'hAA;
      load_prog();
      run_instr();
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      load_en = 1'b1; load_addr = 4'h0; load_data = 8'h1E;
      @(posedge clk); @(negedge clk);
      load_addr = 4'h1; load_data = 8'h80;
      @(posedge clk); @(negedge clk);
      load_en = 1'b0;
      reset = 1'b1;
      m_reset();
      m_mem[0] = 8'h1E; m_mem[1] = 8'h80;
      repeat (2) run_instr();
      chk("sta_abort", int'(out_data), 8'h55);

      // Random programs, including self-modifying code and halts
      for (int p = 0; p < 25; p++) begin
         for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
         load_prog();
         repeat (30) run_instr();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/computer_top.md
COMPUTER_TOP -- requirements
Module: computer_top

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low; ports named as the codebase does (clk, reset).
REQ-002 Parameter: none; widths fixed (8-bit data, 4-bit address, 16-byte memory).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-005 load_en  input  1  program-load write enable, honoured only while reset=0.
REQ-006 load_addr  input  4  program-load memory address.
REQ-007 load_data  input  8  program-load byte.
REQ-008 pc  output  4  current program counter.
REQ-009 acc  output  8  accumulator.
REQ-010 carry  output  1  carry/borrow flag from last ADD/SUB/MUL.
REQ-011 out_data  output  8  last value emitted by OUT.
REQ-012 out_valid  output  1  one-cycle pulse when out_data updated.
REQ-013 halted  output  1  high once HLT executed.

Function
REQ-014 SHALL contain a 16x8 unified instruction/data memory, combinational read, synchronous write; memory SHALL NOT be cleared by reset.
REQ-015 Instruction byte: opcode = bits[7:4], operand address A = bits[3:0]; M = mem[A].
REQ-016 FSM states FETCH -> DECODE -> EXECUTE -> FETCH; HLT goes EXECUTE -> HALT; HALT is absorbing until reset.
REQ-017 FETCH: ir <= mem[pc]; pc <= pc+1 modulo 16 (15 wraps to 0).
REQ-018 DECODE: mdr <= mem[ir[3:0]]; no architectural change.
REQ-019 EXECUTE opcodes: 0 NOP; 1 LDA acc<=M; 2 STA mem[A]<=acc; 3 ADD {carry,acc}<=acc+M; 4 SUB acc<=acc-M, carry<=borrow (acc<M); 5 AND acc<=acc&M; 6 JMP pc<=A; 7 JZ pc<=A if acc==0 else no change; 8 OUT out_data<=acc, out_valid=1 next cycle; 9 MUL (see REQ-025); F HLT; A-E act as NOP.
REQ-020 Every instruction SHALL take exactly 3 clocks; HLT asserts halted on the edge ending its EXECUTE.
REQ-021 LDA/AND/NOP/STA/JMP/JZ/OUT SHALL leave carry unchanged; acc wraps modulo 256.
REQ-022 out_valid SHALL be high exactly one cycle per OUT, low otherwise.
REQ-023 STA to the address of a later instruction SHALL modify that instruction (self-modifying code permitted).

Reset
REQ-024 While reset=0: pc=0, acc=0, carry=0, ir=0, mdr=0, out_data=0, out_valid=0, halted=0, state=FETCH; load_en writes mem[load_addr]<=load_data on each rising clk; on deassertion execution starts at address 0 on the next edge; reset mid-instruction SHALL abort it with no memory write.

Configuration
REQ-025 Macro COMPUTER_MUL_EN: defined -> opcode 9 MUL sets acc<=low 8 bits of acc*M, carry<=1 if high 8 bits nonzero; undefined -> opcode 9 behaves as NOP, no multiplier synthesized.

Verification
REQ-026 Load {0:1E,1:3F,2:80,3:F0,E:05,F:07}, release reset -> out_data=0x0C with one out_valid pulse, then halted=1, pc=4.
REQ-027 Load {0:1E,1:3F,2:F0,E:FF,F:02} -> acc=0x01, carry=1; with {0:1E,1:4F,2:F0,E:01,F:02} -> acc=0xFF, carry=1.
REQ-028 Load {0:1F,1:73,2:F0,3:80,4:F0,F:00} -> JZ taken, out_valid pulses, halted, pc=5; with F:01 -> halted, pc=3, no out_valid.
REQ-029 Load {0:1F,1:9E,2:80,3:F0,E:10,F:20}: with COMPUTER_MUL_EN -> out_data=0x00, carry=1; without -> out_data=0x20, carry=0.
REQ-030 Program {0:60} (JMP 0) runs, assert reset mid-EXECUTE -> all outputs zero immediately; after release pc cycles 0,1,0 per 3 clocks; halted stays 0.
